// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - lock-and-verify monitor for a free-running up-counter
module counter_checker #(
   parameter int WIDTH         = 8,
   parameter int LOCK_COUNT    = 4,
   parameter int ERR_WIDTH     = 8,
   parameter bit ALLOW_RESTART = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [WIDTH-1:0]     value,
   output logic                 locked,
   output logic                 error,
   output logic                 restart,
   output logic [ERR_WIDTH-1:0] err_count,
   output logic [WIDTH-1:0]     bad_value,
   output logic [WIDTH-1:0]     exp_value
);

   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_VERIFY  = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam logic [3:0]           LOCK_TGT = 4'(LOCK_COUNT);
   localparam logic [ERR_WIDTH-1:0] ERR_MAX  = '1;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     expected_q, expected_d;
   logic [3:0]           match_q, match_d;
   logic                 locked_q, locked_d;
   logic                 error_q, error_d;
   logic                 restart_q, restart_d;
   logic [ERR_WIDTH-1:0] err_count_q, err_count_d;
   logic [WIDTH-1:0]     bad_value_q, bad_value_d;
   logic [WIDTH-1:0]     exp_value_q, exp_value_d;

   logic [WIDTH-1:0]     value_inc;
   logic [3:0]           match_inc;
   logic                 is_match;

   assign value_inc = value + WIDTH'(1);
   assign match_inc = match_q + 4'd1;
   assign is_match  = (value == expected_q);

   // Next-state: only enabled samples advance anything; pulses default low every cycle
   always_comb begin
      state_d     = state_q;
      expected_d  = expected_q;
      match_d     = match_q;
      locked_d    = locked_q;
      error_d     = 1'b0;
      restart_d   = 1'b0;
      err_count_d = err_count_q;
      bad_value_d = bad_value_q;
      exp_value_d = exp_value_q;

      if (enable) begin
         unique case (state_q)
            ST_ACQUIRE: begin
               expected_d = value_inc;
               match_d    = 4'd0;
               state_d    = ST_VERIFY;
            end
            ST_VERIFY: begin
               expected_d = value_inc;
               if (is_match) begin
                  match_d = match_inc;
                  if (match_inc == LOCK_TGT) begin
                     state_d  = ST_LOCKED;
                     locked_d = 1'b1;
                  end
               end else begin
                  match_d = 4'd0;
               end
            end
            ST_LOCKED: begin
               if (is_match) begin
                  expected_d = value_inc;
               end else if (ALLOW_RESTART && (value == '0)) begin
                  // a counter legitimately restarted from zero keeps its lock
                  restart_d  = 1'b1;
                  expected_d = WIDTH'(1);
               end else begin
                  error_d     = 1'b1;
                  bad_value_d = value;
                  exp_value_d = expected_q;
                  if (err_count_q != ERR_MAX) begin
                     err_count_d = err_count_q + ERR_WIDTH'(1);
                  end
                  locked_d   = 1'b0;
                  expected_d = value_inc;
                  match_d    = 4'd0;
                  state_d    = ST_VERIFY;
               end
            end
            default: begin
               state_d = ST_ACQUIRE;
            end
         endcase
      end
   end

   // State register with synchronous reset discarding lock and error history
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_ACQUIRE;
         expected_q  <= '0;
         match_q     <= 4'd0;
         locked_q    <= 1'b0;
         error_q     <= 1'b0;
         restart_q   <= 1'b0;
         err_count_q <= '0;
         bad_value_q <= '0;
         exp_value_q <= '0;
      end else begin
         state_q     <= state_d;
         expected_q  <= expected_d;
         match_q     <= match_d;
         locked_q    <= locked_d;
         error_q     <= error_d;
         restart_q   <= restart_d;
         err_count_q <= err_count_d;
         bad_value_q <= bad_value_d;
         exp_value_q <= exp_value_d;
      end
   end

   assign locked    = locked_q;
   assign error     = error_q;
   assign restart   = restart_q;
   assign err_count = err_count_q;
   assign bad_value = bad_value_q;
   assign exp_value = exp_value_q;

endmodule

// File: tb/tb_counter_checker.sv
// tb/tb_counter_checker.sv - scoreboard bench for counter_checker
module tb_counter_checker;

   localparam int WIDTH = 8;
   localparam int LOCKN = 4;
   localparam int ERRW  = 2;
   localparam int MODV  = 1 << WIDTH;
   localparam int EMAX  = (1 << ERRW) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [WIDTH-1:0] value;
   logic             locked, error, restart;
   logic [ERRW-1:0]  err_count;
   logic [WIDTH-1:0] bad_value, exp_value;

   counter_checker #(
      .WIDTH(WIDTH), .LOCK_COUNT(LOCKN), .ERR_WIDTH(ERRW), .ALLOW_RESTART(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .value(value),
      .locked(locked), .error(error), .restart(restart),
      .err_count(err_count), .bad_value(bad_value), .exp_value(exp_value)
   );

   always #5 clk = ~clk;

   typedef struct {
      int l;
      int e;
      int r;
      int cnt;
      int bad;
      int expv;
   } resp_t;

   resp_t sb[$];
   int    checks = 0;
   int    errors = 0;

   // reference model: plain integers describing the sequence history
   bit m_seen;
   bit m_locked;
   int m_next;
   int m_run;
   int m_cnt;
   int m_bad;
   int m_expv;
   int cur;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
      end
   endtask

   task automatic step(input bit rst, input bit en, input int v);
      resp_t r;
      @(negedge clk);
      reset  = rst;
      enable = en;
      value  = WIDTH'(v);
      r.e = 0;
      r.r = 0;
      if (rst) begin
         m_seen = 0; m_locked = 0; m_next = 0; m_run = 0;
         m_cnt = 0; m_bad = 0; m_expv = 0;
      end else if (en) begin
         if (!m_seen) begin
            m_seen = 1;
            m_run  = 0;
         end else if (!m_locked) begin
            if (v == m_next) begin
               m_run++;
               if (m_run == LOCKN) m_locked = 1;
            end else begin
               m_run = 0;
            end
         end else if (v != m_next) begin
            if (v == 0) begin
               r.r = 1;
            end else begin
               r.e = 1;
               if (m_cnt < EMAX) m_cnt++;
               m_bad    = v;
               m_expv   = m_next;
               m_locked = 0;
               m_run    = 0;
            end
         end
         m_next = (v + 1) % MODV;
      end
      r.l = m_locked; r.cnt = m_cnt; r.bad = m_bad; r.expv = m_expv;
      sb.push_back(r);
   endtask

   // feed an incrementing run starting at v
   task automatic run_from(input int v, input int n);
      for (int i = 0; i < n; i++) begin
         cur = (v + i) % MODV;
         step(0, 1, cur);
      end
   endtask

   // monitor: every cycle after an issued sample the DUT presents its registered response
   initial begin
      resp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("locked",    int'(locked),    e.l);
            chk("error",     int'(error),     e.e);
            chk("restart",   int'(restart),   e.r);
            chk("err_count", int'(err_count), e.cnt);
            chk("bad_value", int'(bad_value), e.bad);
            chk("exp_value", int'(exp_value), e.expv);
         end
      end
   end

   initial begin
      reset = 1'b1; enable = 1'b0; value = '0;
      step(1, 0, 0);
      step(1, 1, 5);
      // acquire at 0x10, lock after 0x14, run to expected 0x23
      run_from(8'h10, 19);
      // restart to zero, then 0x01.. up to 0x3F so expected is 0x40
      run_from(8'h00, 64);
      // mismatch 0x55 then re-lock on 0x56..0x59, keep going
      run_from(8'h55, 6);
      // enable dropped for 3 cycles with value frozen, then resume
      for (int i = 0; i < 3; i++) step(0, 0, cur);
      run_from(cur + 1, 4);
      // repeated mismatches to drive the 2-bit error counter into saturation
      for (int k = 0; k < 4; k++) begin
         run_from(8'h80 + 16 * k, 5);
      end
      // reset while locked, then re-acquire and lock across the wrap
      step(1, 1, 8'h33);
      run_from(8'hF9, 9);
      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         int sel;
         sel = $urandom_range(0, 199);
         if (sel == 0) begin
            step(1, $urandom_range(0, 1), $urandom_range(0, MODV - 1));
         end else if (sel < 25) begin
            step(0, 0, cur);
         end else if (sel < 31) begin
            cur = 0;
            step(0, 1, cur);
         end else if (sel < 39) begin
            cur = $urandom_range(0, MODV - 1);
            step(0, 1, cur);
         end else begin
            cur = (cur + 1) % MODV;
            step(0, 1, cur);
         end
      end
      step(0, 0, cur);
      @(posedge clk);
      #2;
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Sequential monitor that sits on the output bus of a free-running up-counter and checks the sequence it produces.
- Acquires lock on the incoming count and verifies each sample equals the previous sample + 1, modulo 2^WIDTH.
- Flags mismatches, counts them, and tolerates a legitimate restart of the counter to zero.
- Serves as the reader side of the counter value interface, both in benches and in on-chip self-test.

Parameters:
- WIDTH, 8, width of the observed count value.
- LOCK_COUNT, 4, consecutive correct increments required before locked asserts (range 1..15).
- ERR_WIDTH, 8, width of the saturating error counter.
- ALLOW_RESTART, 1, when 1 a jump to 0 while locked is a restart, not an error.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  sample qualifier; value is sampled only on edges where enable=1.
- value  in  WIDTH  count value under observation.
- locked  out  1  high while the sequence is tracked and verified.
- error  out  1  one-cycle pulse on a detected mismatch.
- restart  out  1  one-cycle pulse on an accepted restart to zero.
- err_count  out  ERR_WIDTH  total mismatches since reset; saturates at all-ones.
- bad_value  out  WIDTH  value sampled at the most recent mismatch.
- exp_value  out  WIDTH  value expected at the most recent mismatch.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values (on any edge with reset=1, which overrides everything): state=ACQUIRE; locked=0; error=0; restart=0; err_count=0; bad_value=0; exp_value=0; internal expected=0; match counter=0.
- Reset asserted mid-operation discards lock and history on that edge.
- All outputs are registered. A sample taken at edge N produces its response visible after edge N, i.e. 1-cycle latency.
- error and restart are single-cycle pulses.
- enable=0: no sampling, state and internal registers hold, error and restart are 0.
- Next-expected value: expected = (sample + 1) mod 2^WIDTH. Wrap from all-ones to 0 is a correct increment.
- State machine, evaluated on enabled samples only:
  - ACQUIRE: load expected = sample+1, match counter=0, go to VERIFY. No error is possible in this state.
  - VERIFY, sample == expected: match counter +1, expected = sample+1. When the counter reaches LOCK_COUNT, go to LOCKED and set locked=1 on the same edge.
  - VERIFY, sample != expected: stay in VERIFY, reseed expected = sample+1, match counter=0. No error pulse, no err_count change.
  - LOCKED, sample == expected: expected = sample+1. This includes a wrap to 0, which gives no restart pulse.
  - LOCKED, sample == 0 and != expected, with ALLOW_RESTART=1: restart=1, expected=1, stay LOCKED.
  - LOCKED, any other mismatch: error=1; err_count +1 (saturating); bad_value=sample; exp_value=expected; locked=0; reseed expected = sample+1, match counter=0; go to VERIFY.
- err_count at all-ones stays all-ones; error still pulses.
- Unsigned arithmetic throughout. The compare is a full WIDTH-bit equality.

Test Plan:
- Reset, then enable=1 with value 0x10,0x11,… one per cycle -> locked=0 through the 0x14 sample, locked=1 after the 0x14 edge (LOCK_COUNT=4); error never pulses.
- Locked, value 0xFE,0xFF,0x00,0x01 -> locked stays 1; no error; no restart.
- Locked at expected 0x23, drive 0x00 (ALLOW_RESTART=1) -> restart pulses 1 cycle; then 0x01,0x02 accepted; err_count=0.
- Locked at expected 0x40, drive 0x55 -> error pulse 1 cycle; err_count=1; bad_value=0x55; exp_value=0x40; locked=0; then 0x56..0x59 re-lock after the 0x59 edge.
- Repeated mismatches with ERR_WIDTH=2 -> err_count reaches 3 and holds at 3; error still pulses each time.
- Mid-run: drop enable 3 cycles while value freezes then resumes +1 -> no error. Assert reset 1 cycle while locked -> all outputs 0 next cycle and re-acquire follows.
